// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised storage behind an AHB data phase with
// configurable wait states, byte/halfword/word writes and ERROR responses.
module ahb_sram_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = {ADDR_WIDTH{1'b0}},
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic                  hmastlock,
    input  logic [3:0]            hmaster,
    input  logic                  hnonsec,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic                  hready,
    output logic [1:0]            hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int                  IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);
    localparam logic [3:0]          WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    logic [2:0]            state_r;
    logic [2:0]            state_nxt_s;
    logic [3:0]            cnt_r;
    logic [3:0]            cnt_nxt_s;
    logic [IDX_W-1:0]      idx_r;
    logic [1:0]            lane_r;
    logic [1:0]            size_r;
    logic                  write_r;
    logic [ADDR_WIDTH-1:0] offset_s;
    logic                  err_s;
    logic                  accept_s;
    logic [3:0]            be_s;
    logic                  unused_s;
    logic [DATA_WIDTH-1:0] mem_r [0:MEM_DEPTH-1];

    // Little-endian lane enables for a naturally aligned transfer.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << lane;
            2'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    assign offset_s = haddr - BASE_ADDR;
    assign accept_s = hready & hsel & htrans[1];
    assign be_s     = byte_en(size_r, lane_r);
    assign unused_s = ^{hburst, hprot, hmastlock, hmaster, hnonsec, htrans[0]};

    // Error decode of the address phase: range and alignment.
    always_comb begin
        err_s = 1'b0;
        if ({1'b0, offset_s} >= MEM_BYTES) begin
            err_s = 1'b1;
        end else if (hsize > 3'd2) begin
            err_s = 1'b1;
        end else if ((hsize == 3'd1) && haddr[0]) begin
            err_s = 1'b1;
        end else if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Next-state and wait counter; new transfers only start from hready-high states.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_s) begin
                    if (err_s) begin
                        state_nxt_s = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = WAIT_LOAD;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_ERR1: state_nxt_s = ST_ERR2;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Bus response decoded purely from the state flops.
    always_comb begin
        case (state_r)
            ST_IDLE: begin hready = 1'b1; hresp = 2'b00; end
            ST_WAIT: begin hready = 1'b0; hresp = 2'b00; end
            ST_DATA: begin hready = 1'b1; hresp = 2'b00; end
            ST_ERR1: begin hready = 1'b0; hresp = 2'b01; end
            ST_ERR2: begin hready = 1'b1; hresp = 2'b01; end
            default: begin hready = 1'b1; hresp = 2'b00; end
        endcase
    end

    // Read data is only presented during a read data phase.
    always_comb begin
        if ((state_r == ST_DATA) && !write_r) begin
            hrdata = mem_r[idx_r];
        end else begin
            hrdata = {DATA_WIDTH{1'b0}};
        end
    end

    // State, counter and captured address-phase control.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= {IDX_W{1'b0}};
            lane_r  <= 2'b00;
            size_r  <= 2'b00;
            write_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (accept_s) begin
                idx_r   <= offset_s[IDX_W+1:2];
                lane_r  <= haddr[1:0];
                size_r  <= hsize[1:0];
                write_r <= hwrite;
            end
        end
    end

    // Storage array; commits in the write DATA cycle, which reset removes.
    always_ff @(posedge hclk) begin
        if ((state_r == ST_DATA) && write_r) begin
            for (int k = 0; k < 4; k++) begin
                if (be_s[k]) begin
                    mem_r[idx_r][8*k +: 8] <= hwdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomized self-checking bench for ahb_sram_slave: one instance with one
// wait state and one with none, both checked against a byte-level memory model.
module tb_ahb_sram_slave;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        use0;

    logic        hsel_a, hsel_b;
    logic        hready_a, hready_b;
    logic [1:0]  hresp_a, hresp_b;
    logic [31:0] hrdata_a, hrdata_b;
    logic        hready_m;
    logic [1:0]  hresp_m;
    logic [31:0] hrdata_m;

    int total = 0;
    int bad   = 0;
    logic [31:0] ref_mem [2][256];
    logic [31:0] stream_d [4];
    logic [31:0] rd;

    always #5 hclk = ~hclk;

    assign hsel_a   = hsel & ~use0;
    assign hsel_b   = hsel & use0;
    assign hready_m = use0 ? hready_b : hready_a;
    assign hresp_m  = use0 ? hresp_b  : hresp_a;
    assign hrdata_m = use0 ? hrdata_b : hrdata_a;

    ahb_sram_slave #(.WAIT_STATES(1)) u_dut_ws1 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hprot(4'd0), .hmastlock(1'b0),
        .hmaster(4'd0), .hnonsec(1'b0), .hwdata(hwdata),
        .hready(hready_a), .hresp(hresp_a), .hrdata(hrdata_a)
    );

    ahb_sram_slave #(.WAIT_STATES(0)) u_dut_ws0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(3'd1), .hprot(4'd3), .hmastlock(1'b0),
        .hmaster(4'd0), .hnonsec(1'b0), .hwdata(hwdata),
        .hready(hready_b), .hresp(hresp_b), .hrdata(hrdata_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        hsel = 1'b0;
        htrans = 2'b00;
        @(posedge hclk); #1;
    endtask

    // One transfer: address phase, then walk the data phase to hready=1.
    task automatic xfer(input string tag, input logic [1:0] tr, input logic [31:0] addr,
                        input logic wr, input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rdo);
        logic        err;
        int          d, lows, nbytes, lane;
        logic [31:0] exp_rd;
        logic [9:0]  b;
        d   = use0 ? 1 : 0;
        err = (addr >= 32'd1024) || (sz > 3'd2) || (sz == 3'd1 && addr[0]) ||
              (sz == 3'd2 && addr[1:0] != 2'b00);
        exp_rd = ref_mem[d][addr[9:2]];
        hsel = 1'b1; htrans = tr; haddr = addr; hwrite = wr; hsize = sz;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        lows = 0;
        while (hready_m !== 1'b1 && lows < 20) begin
            check({tag, ".resp_low"}, {30'd0, hresp_m}, err ? 32'd1 : 32'd0);
            lows++;
            @(posedge hclk); #1;
        end
        check({tag, ".lows"}, 32'(lows), err ? 32'd1 : (use0 ? 32'd0 : 32'd1));
        check({tag, ".resp"}, {30'd0, hresp_m}, err ? 32'd1 : 32'd0);
        check({tag, ".rdata"}, hrdata_m, (!err && !wr) ? exp_rd : 32'd0);
        rdo = hrdata_m;
        if (!err && wr) begin
            nbytes = 1 << sz;
            for (int k = 0; k < nbytes; k++) begin
                b    = addr[9:0] + 10'(k);
                lane = int'(b[1:0]);
                ref_mem[d][b[9:2]][8*lane +: 8] = wd[8*lane +: 8];
            end
        end
    endtask

    task automatic noop(input string tag, input logic s, input logic [1:0] tr);
        hsel = s; htrans = tr; haddr = $urandom & 32'h3FC; hwrite = 1'($urandom); hsize = 3'd2;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00;
        check({tag, ".ready"}, {31'd0, hready_m}, 32'd1);
        check({tag, ".resp"}, {30'd0, hresp_m}, 32'd0);
        check({tag, ".rdata"}, hrdata_m, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hresetn = 1'b0; hsel = 1'b0; haddr = 32'd0; htrans = 2'b00;
        hwrite = 1'b0; hsize = 3'd2; hwdata = 32'd0; use0 = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge hclk); #1;
            check("rst.ready", {30'd0, hready_a, hready_b}, 32'd3);
            check("rst.resp", {28'd0, hresp_a, hresp_b}, 32'd0);
            check("rst.rdata", hrdata_a | hrdata_b, 32'd0);
        end
        hresetn = 1'b1;
        @(posedge hclk); #1;
        check("rel.ready", {30'd0, hready_a, hready_b}, 32'd3);
        check("rel.resp", {28'd0, hresp_a, hresp_b}, 32'd0);
        check("rel.rdata", hrdata_a | hrdata_b, 32'd0);

        for (int d = 0; d < 2; d++) begin
            use0 = (d == 1);
            for (int w = 0; w < 256; w++) begin
                xfer("init", 2'b10, 32'(w * 4), 1'b1, 3'd2, $urandom, rd);
            end
        end
        idle();

        use0 = 1'b0;
        xfer("wr10", 2'b10, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, rd);
        xfer("rd10", 2'b10, 32'h10, 1'b0, 3'd2, 32'h0, rd);
        check("rd10.const", rd, 32'hDEADBEEF);

        xfer("w11", 2'b10, 32'h10, 1'b1, 3'd2, 32'h11223344, rd);
        xfer("wb13", 2'b10, 32'h13, 1'b1, 3'd0, 32'hAA000000, rd);
        xfer("rbyte", 2'b10, 32'h10, 1'b0, 3'd2, 32'h0, rd);
        check("rbyte.const", rd, 32'hAA223344);
        xfer("wh10", 2'b10, 32'h10, 1'b1, 3'd1, 32'h0000BEEF, rd);
        xfer("rhalf", 2'b10, 32'h10, 1'b0, 3'd2, 32'h0, rd);
        check("rhalf.const", rd, 32'hAA22BEEF);

        xfer("erd400", 2'b10, 32'h400, 1'b0, 3'd2, 32'h0, rd);
        xfer("ewr12", 2'b10, 32'h12, 1'b1, 3'd2, 32'h12345678, rd);
        xfer("rafter", 2'b10, 32'h10, 1'b0, 3'd2, 32'h0, rd);
        check("rafter.const", rd, 32'hAA22BEEF);

        noop("n_idle", 1'b1, 2'b00);
        noop("n_busy", 1'b1, 2'b01);
        noop("n_nosel", 1'b0, 2'b10);
        xfer("rnoop", 2'b10, 32'h10, 1'b0, 3'd2, 32'h0, rd);
        check("rnoop.const", rd, 32'hAA22BEEF);

        use0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stream_d[i] = $urandom;
            xfer("sw", (i == 0) ? 2'b10 : 2'b11, 32'h20 + 32'(4 * i), 1'b1, 3'd2, stream_d[i], rd);
        end
        for (int i = 0; i < 4; i++) begin
            xfer("sr", (i == 0) ? 2'b10 : 2'b11, 32'h20 + 32'(4 * i), 1'b0, 3'd2, 32'h0, rd);
            check("sr.const", rd, stream_d[i]);
        end
        xfer("b2b_w", 2'b10, 32'h30, 1'b1, 3'd2, 32'hCAFEF00D, rd);
        xfer("b2b_r", 2'b11, 32'h30, 1'b0, 3'd2, 32'h0, rd);
        check("b2b.const", rd, 32'hCAFEF00D);

        use0 = 1'b0;
        idle();
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h55667788;
        check("r38.wait", {31'd0, hready_a}, 32'd0);
        hresetn = 1'b0;
        #2;
        check("r38.ready", {31'd0, hready_a}, 32'd1);
        check("r38.resp", {30'd0, hresp_a}, 32'd0);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;
        xfer("r38.rd", 2'b10, 32'h10, 1'b0, 3'd2, 32'h0, rd);
        check("r38.const", rd, 32'hAA22BEEF);

        for (int n = 0; n < 300; n++) begin
            int r;
            logic [31:0] a;
            r    = int'($urandom_range(0, 9));
            use0 = 1'($urandom_range(0, 1));
            if (r < 2) begin
                noop("rnd_noop", 1'($urandom), ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01);
            end else begin
                a = (r == 2) ? 32'h400 + ($urandom & 32'hFFF) : 32'($urandom_range(0, 1023));
                xfer("rnd", ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11, a, 1'($urandom),
                     3'($urandom_range(0, 3)), $urandom, rd);
            end
        end
        idle();

        for (int d = 0; d < 2; d++) begin
            use0 = (d == 1);
            for (int w = 0; w < 64; w++) begin
                xfer("final", 2'b10, 32'(w * 4), 1'b0, 3'd2, 32'h0, rd);
            end
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, 32, address bus width.
REQ-002 Parameter DATA_WIDTH, 32, data bus width; only 32 is supported.
REQ-003 Parameter MEM_DEPTH, 256, number of 32-bit words of storage.
REQ-004 Parameter BASE_ADDR, 0, byte address of word 0; must be 4-byte aligned.
REQ-005 Parameter WAIT_STATES, 1, number of hready-low cycles per OKAY data phase; legal range 0..15.
REQ-006 hclk  in  1  bus clock; all state updates on the rising edge.
REQ-007 hresetn  in  1  asynchronous, active-low reset.
REQ-008 hsel  in  1  slave select.
REQ-009 haddr  in  ADDR_WIDTH  byte address.
REQ-010 htrans  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-011 hwrite  in  1  1 = write.
REQ-012 hsize  in  3  transfer size: 0 = byte, 1 = halfword, 2 = word.
REQ-013 hburst, hprot, hmastlock, hmaster, hnonsec  in  3, 4, 1, 4, 1  accepted and ignored.
REQ-014 hwdata  in  DATA_WIDTH  write data, valid in the data phase.
REQ-015 hready  out  1  transfer done / address accepted; it is also the slave's internal accept qualifier (single-slave bus).
REQ-016 hresp  out  2  00 = OKAY, 01 = ERROR.
REQ-017 hrdata  out  DATA_WIDTH  read data.

Function
REQ-018 Accept condition: a transfer is accepted when hready=1, hsel=1 and htrans[1]=1; on acceptance haddr, hwrite and hsize are registered.
REQ-019 IDLE/BUSY transfers, and any transfer with hsel=0, produce no data phase; hready stays 1 and hresp stays OKAY.
REQ-020 Error decode at acceptance:
  - offset = haddr - BASE_ADDR;
  - ERROR if offset >= MEM_DEPTH*4;
  - ERROR if hsize > 2;
  - ERROR if hsize=1 and haddr[0]=1;
  - ERROR if hsize=2 and haddr[1:0] != 0.
REQ-021 FSM states: IDLE, WAIT, DATA, ERR1, ERR2. Outputs per state:
  - IDLE: hready=1, hresp=00;
  - WAIT: hready=0, hresp=00;
  - DATA: hready=1, hresp=00;
  - ERR1: hready=0, hresp=01;
  - ERR2: hready=1, hresp=01.
REQ-022 Transitions from IDLE, DATA and ERR2, on the accept condition:
  - errored transfer -> ERR1;
  - else WAIT_STATES>0 -> WAIT with the counter loaded to WAIT_STATES-1;
  - else -> DATA.
  Without the accept condition -> IDLE.
REQ-023 WAIT decrements the counter each cycle and goes to DATA when the counter is 0; WAIT_STATES=N therefore gives N hready-low cycles.
REQ-024 ERR1 always goes to ERR2 next cycle; no transfer is accepted in ERR1 or WAIT.
REQ-025 DATA write: in the DATA cycle, hwdata is written to mem[offset>>2] under byte enables:
  - byte: lane haddr[1:0];
  - halfword: lanes {haddr[1],0} and {haddr[1],1};
  - word: all lanes;
  - little-endian; lane k = hwdata[8k+7:8k].
REQ-026 DATA read: in the DATA cycle, hrdata = the full 32-bit word mem[offset>>2]; hrdata = 0 in all other states and for writes.
REQ-027 Errored transfers never modify memory.
REQ-028 Back-to-back: with WAIT_STATES=0, a read at the address written in the immediately preceding data phase returns the new data; no bypass is needed because the write commits in the earlier DATA cycle.
REQ-029 hready is driven from flops (state decode); the path from hsel/htrans to hready is not combinational.

Reset
REQ-030 While hresetn=0: state=IDLE, counter=0, hready=1, hresp=00, hrdata=0, registered address/control=0.
REQ-031 Memory contents are not reset.
REQ-032 Reset asserted mid-WAIT or mid-ERR1 aborts the transfer; a pending write is not performed.

Verification
REQ-033 Reset: hresetn=0 for 3 cycles -> hready=1, hresp=00, hrdata=0 throughout and on the first cycle after release.
REQ-034 WAIT_STATES=1: word write 0xDEADBEEF to 0x10, then NONSEQ read of 0x10 -> each data phase shows 1 hready-low cycle; read DATA cycle gives hrdata=0xDEADBEEF, hresp=00.
REQ-035 Word 0x11223344 at 0x10; byte write at 0x13 with hwdata=0xAA000000; read 0x10 -> 0xAA223344. Then halfword write at 0x10 with hwdata=0x0000BEEF -> read gives 0xAA22BEEF.
REQ-036 Read at 0x400 (MEM_DEPTH=256), and separately a word write at 0x12 -> cycle 1 hready=0/hresp=01, cycle 2 hready=1/hresp=01; memory unchanged.
REQ-037 hsel=1 with htrans=IDLE/BUSY, and hsel=0 with NONSEQ -> hready stays 1, hresp=00, memory unchanged. WAIT_STATES=0 streaming of 4 SEQ writes then 4 reads -> no hready-low cycles and correct data.
REQ-038 Write accepted, then hresetn pulsed low during WAIT -> IDLE with hready=1; later read of that address returns its prior value.
